spio_spinnaker_link_synchronous_sender: RTL and testbench

// - Serialises 72-bit SpiNNaker packets onto an outgoing SpiNNaker link.
// - Link uses NRZ 2-of-7 coding with a toggling (transition) ack.
// - Fully synchronous to CLK_IN; the asynchronous SL_ACK_IN is synchronised internally.
// - Sits between the packet fabric (valid/ready) and the off-chip link pins.

---
 rtl/spio_spinnaker_link_synchronous_sender_pkg.sv | 50 +++++
 rtl/spio_spinnaker_link_synchronous_sender_ack_sync.sv | 37 +++
 rtl/spio_spinnaker_link_synchronous_sender.sv | 151 +++++++++++++++
 tb/tb_spio_spinnaker_link_synchronous_sender.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spio_spinnaker_link_synchronous_sender_pkg.sv
// Shared definitions for the SpiNNaker link sender: packet field layout,
// NRZ 2-of-7 symbol table, end-of-packet mask, flit counts and FSM states.
package spio_spinnaker_link_synchronous_sender_pkg;

    localparam int PKT_W        = 72;
    localparam int HDR_LSB      = 0;
    localparam int HDR_W        = 8;
    localparam int KEY_LSB      = 8;
    localparam int KEY_W        = 32;
    localparam int PLD_LSB      = 40;
    localparam int PLD_W        = 32;
    localparam int HDR_LONG_BIT = 1;

    localparam int SHORT_FLITS  = 10;
    localparam int LONG_FLITS   = 18;

    localparam logic [6:0] EOP_MASK = 7'b1100000;

    typedef enum logic [1:0] {
        ST_WAIT_LINK,
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK
    } sender_state_t;

    // Toggle mask for one data nibble on the NRZ 2-of-7 link.
    function automatic logic [6:0] code_2of7(input logic [3:0] nibble);
        logic [6:0] mask;
        case (nibble)
            4'h0:    mask = 7'b0010001;
            4'h1:    mask = 7'b0010010;
            4'h2:    mask = 7'b0010100;
            4'h3:    mask = 7'b0011000;
            4'h4:    mask = 7'b0100001;
            4'h5:    mask = 7'b0100010;
            4'h6:    mask = 7'b0100100;
            4'h7:    mask = 7'b0101000;
            4'h8:    mask = 7'b1000001;
            4'h9:    mask = 7'b1000010;
            4'hA:    mask = 7'b1000100;
            4'hB:    mask = 7'b1001000;
            4'hC:    mask = 7'b0000011;
            4'hD:    mask = 7'b0000110;
            4'hE:    mask = 7'b0001100;
            default: mask = 7'b0001001;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/spio_spinnaker_link_synchronous_sender_ack_sync.sv
// Brings the asynchronous link ack into the clock domain and flags every
// transition of the synchronised level as a one-cycle edge.
module spio_sl_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic ack_in,
    output logic ack_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Shift the raw ack through the synchroniser and remember the last settled level.
    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = ack_in;
        prev_d    = sync_q[SYNC_STAGES-1];
    end

    assign ack_edge = sync_q[SYNC_STAGES-1] ^ prev_q;

    // Synchroniser and edge-history registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/spio_spinnaker_link_synchronous_sender.sv
// Serialises 72-bit SpiNNaker packets onto an NRZ 2-of-7 link with a
// transition ack. One packet buffer, one symbol in flight at a time.
module spio_spinnaker_link_synchronous_sender #(
    parameter int SYNC_STAGES = 2,
    parameter int TMO_CYCLES  = 1024
) (
    input  logic        CLK_IN,
    input  logic        RESET_IN,
    output logic        ACK_ERR_OUT,
    output logic        TMO_ERR_OUT,
    input  logic [71:0] PKT_DATA_IN,
    input  logic        PKT_VLD_IN,
    output logic        PKT_RDY_OUT,
    output logic [6:0]  SL_DATA_2OF7_OUT,
    input  logic        SL_ACK_IN
);

    import spio_spinnaker_link_synchronous_sender_pkg::*;

    localparam int TMO_W = $clog2(TMO_CYCLES + 1);

    sender_state_t          state_q, state_d;
    logic [PKT_W-1:0]       buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   rdy_q, rdy_d;
    logic [4:0]             flit_q, flit_d;
    logic [6:0]             data_q, data_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   ack_err_q, ack_err_d;
    logic                   tmo_err_q, tmo_err_d;

    logic                   ack_edge;
    logic [HDR_W-1:0]       hdr;
    logic [4:0]             last_flit;
    logic                   at_eop;
    logic [3:0]             nibble;
    logic [6:0]             sym_mask;
    logic                   accept;

    spio_sl_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clock    (CLK_IN),
        .reset    (RESET_IN),
        .ack_in   (SL_ACK_IN),
        .ack_edge (ack_edge)
    );

    // Pick the symbol for the current flit: a data nibble or, after the last one, EOP.
    always_comb begin
        hdr       = buf_q[HDR_LSB +: HDR_W];
        last_flit = hdr[HDR_LONG_BIT] ? 5'(LONG_FLITS) : 5'(SHORT_FLITS);
        at_eop    = (flit_q == last_flit);
        nibble    = 4'(buf_q >> {flit_q, 2'b00});
        sym_mask  = at_eop ? EOP_MASK : code_2of7(nibble);
        accept    = PKT_VLD_IN & rdy_q;
    end

    // Link FSM: wait for the link, send a symbol, wait for its ack; buffer capture runs alongside.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        flit_d     = flit_q;
        data_d     = data_q;
        tmo_d      = tmo_q;
        ack_err_d  = 1'b0;
        tmo_err_d  = 1'b0;

        if (accept) begin
            buf_d      = PKT_DATA_IN;
            buf_full_d = 1'b1;
        end

        case (state_q)
            ST_WAIT_LINK: begin
                if (ack_edge) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ack_edge) begin
                    ack_err_d = 1'b1;
                end
                if (buf_full_q) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ack_edge) begin
                    ack_err_d = 1'b1;
                end
                data_d  = data_q ^ sym_mask;
                tmo_d   = '0;
                state_d = ST_WAIT_ACK;
                if (at_eop) begin
                    flit_d     = '0;
                    buf_full_d = 1'b0;
                end else begin
                    flit_d = flit_q + 5'd1;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_edge) begin
                    state_d = buf_full_q ? ST_SEND : ST_IDLE;
                end else if (tmo_q != TMO_W'(TMO_CYCLES)) begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_W'(TMO_CYCLES - 1)) begin
                        tmo_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_LINK;
            end
        endcase

        rdy_d = ~buf_full_d;
    end

    // State and datapath registers; reset discards any packet in progress.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q    <= ST_WAIT_LINK;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            rdy_q      <= 1'b0;
            flit_q     <= '0;
            data_q     <= '0;
            tmo_q      <= '0;
            ack_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            rdy_q      <= rdy_d;
            flit_q     <= flit_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
            ack_err_q  <= ack_err_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign PKT_RDY_OUT      = rdy_q;
    assign SL_DATA_2OF7_OUT = data_q;
    assign ACK_ERR_OUT      = ack_err_q;
    assign TMO_ERR_OUT      = tmo_err_q;

endmodule

// File: tb/tb_spio_spinnaker_link_synchronous_sender.sv
// Bench for the SpiNNaker link sender: acts as the link receiver, decodes
// the 2-of-7 stream back into packets and compares against offered packets.
`timescale 1ns/1ps
module tb_spio_spinnaker_link_synchronous_sender;

    localparam int SYNC_STAGES = 2;
    localparam int TMO_CYCLES  = 1024;
    localparam int LAT_MAX     = SYNC_STAGES + 2;
    localparam logic [6:0] EOP = 7'b1100000;
    localparam logic [6:0] CODE_TAB [16] = '{
        7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
        7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
        7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
        7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001
    };

    logic        tb_clk   = 1'b0;
    logic        tb_rst   = 1'b1;
    logic [71:0] pkt_data = '0;
    logic        pkt_vld  = 1'b0;
    logic        pkt_rdy;
    logic [6:0]  sl_data;
    logic        sl_ack   = 1'b0;
    logic        ack_err;
    logic        tmo_err;

    spio_spinnaker_link_synchronous_sender #(
        .SYNC_STAGES (SYNC_STAGES),
        .TMO_CYCLES  (TMO_CYCLES)
    ) dut (
        .CLK_IN           (tb_clk),
        .RESET_IN         (tb_rst),
        .ACK_ERR_OUT      (ack_err),
        .TMO_ERR_OUT      (tmo_err),
        .PKT_DATA_IN      (pkt_data),
        .PKT_VLD_IN       (pkt_vld),
        .PKT_RDY_OUT      (pkt_rdy),
        .SL_DATA_2OF7_OUT (sl_data),
        .SL_ACK_IN        (sl_ack)
    );

    always #5 tb_clk = ~tb_clk;

    int checks   = 0;
    int failures = 0;

    // Receiver / reference model state
    logic [6:0]  exp_sym [$];
    logic [71:0] exp_pkt [$];
    logic [6:0]  pin_log [$];
    logic        model_link_up  = 1'b0;
    logic        model_buf_full = 1'b0;
    logic        outstanding    = 1'b0;
    int          pending        = 0;
    logic [6:0]  prev_data      = '0;
    logic [71:0] rx_data        = '0;
    int          rx_nib         = 0;
    int          rx_pkt_cnt     = 0;
    logic [71:0] last_rx_pkt    = '0;
    int          rx_sym_total   = 0;
    logic        lat_armed      = 1'b0;
    int          lat_wait       = 0;
    int          nr_cnt         = 0;
    int          ack_req = 0, ack_done = 0;
    int          tmo_req = 0, tmo_done = 0;
    int          exp_ack_err = 0, exp_tmo_err = 0;
    int          ack_err_cnt = 0, tmo_err_cnt = 0;

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s", name);
    endtask

    function automatic int ref_decode(input logic [6:0] sym);
        for (int i = 0; i < 16; i++) begin
            if (CODE_TAB[i] == sym) return i;
        end
        if (sym == EOP) return 16;
        return -1;
    endfunction

    // Link receiver and compare process: decodes symbols, acks them, checks every output.
    always @(negedge tb_clk) begin
        logic [6:0]  sym;
        logic [71:0] exp_p;
        int          nib;
        int          n;
        bit          got;
        got = 1'b0;
        if (tb_rst) begin
            checkOutput("reset_outputs", 72'({sl_data, pkt_rdy, ack_err, tmo_err}), 72'd0);
            exp_sym.delete();
            exp_pkt.delete();
            model_link_up  = 1'b0;
            model_buf_full = 1'b0;
            outstanding    = 1'b0;
            pending        = 0;
            prev_data      = '0;
            rx_data        = '0;
            rx_nib         = 0;
            lat_armed      = 1'b0;
            nr_cnt         = 0;
            sl_ack         = 1'b0;
            ack_done       = ack_req;
            tmo_done       = tmo_req;
        end else begin
            nr_cnt++;
            if (ack_err) ack_err_cnt++;
            if (tmo_err) tmo_err_cnt++;
            if (lat_armed) lat_wait++;
            if (sl_data !== prev_data) begin
                got = 1'b1;
                sym = sl_data ^ prev_data;
                prev_data = sl_data;
                pin_log.push_back(sl_data);
                rx_sym_total++;
                if (!model_link_up) failNow("symbol_before_link_up");
                if (outstanding) failNow("symbol_while_in_flight");
                if (lat_armed) begin
                    checkOutput("ack_to_data_latency_ok", 72'(lat_wait <= LAT_MAX), 72'd1);
                    lat_armed = 1'b0;
                end
                if (exp_sym.size() == 0) failNow("unexpected_symbol");
                else checkOutput("symbol_mask", 72'(sym), 72'(exp_sym.pop_front()));
                nib = ref_decode(sym);
                if (nib < 0) begin
                    failNow("invalid_2of7_code");
                end else if (nib == 16) begin
                    if (exp_pkt.size() == 0) begin
                        failNow("unexpected_eop");
                    end else begin
                        exp_p = exp_pkt.pop_front();
                        checkOutput("packet_length", 72'(rx_nib), exp_p[1] ? 72'd18 : 72'd10);
                        if (!exp_p[1]) exp_p[71:40] = '0;
                        checkOutput("packet_data", rx_data, exp_p);
                    end
                    last_rx_pkt = rx_data;
                    rx_pkt_cnt++;
                    rx_data = '0;
                    rx_nib = 0;
                    model_buf_full = 1'b0;
                end else begin
                    if (rx_nib < 18) rx_data[rx_nib*4 +: 4] = nib[3:0];
                    rx_nib++;
                end
                outstanding = 1'b1;
                if (tmo_req != tmo_done) begin
                    pending = TMO_CYCLES;
                    tmo_done++;
                    exp_tmo_err++;
                end else begin
                    pending = int'($urandom_range(0, 3));
                end
            end
            if (lat_armed && !got && lat_wait >= LAT_MAX) begin
                failNow("ack_to_data_latency_expired");
                lat_armed = 1'b0;
            end
            if (nr_cnt > 1) checkOutput("pkt_rdy", 72'(pkt_rdy), 72'(!model_buf_full));
            if (pkt_vld && pkt_rdy) begin
                n = pkt_data[1] ? 18 : 10;
                for (int i = 0; i < n; i++) exp_sym.push_back(CODE_TAB[pkt_data[i*4 +: 4]]);
                exp_sym.push_back(EOP);
                exp_pkt.push_back(pkt_data);
                model_buf_full = 1'b1;
            end
            if (outstanding && !got) begin
                if (pending == 0) begin
                    sl_ack = ~sl_ack;
                    outstanding = 1'b0;
                    if (exp_sym.size() != 0) begin
                        lat_armed = 1'b1;
                        lat_wait = 0;
                    end
                end else begin
                    pending--;
                end
            end else if (!outstanding && ack_req != ack_done) begin
                sl_ack = ~sl_ack;
                ack_done++;
                if (model_link_up) exp_ack_err++;
                else model_link_up = 1'b1;
            end
        end
    end

    // Offer one packet after a gap and hold it until the handshake completes.
    task automatic applyStimulus(input logic [71:0] p, input int gap);
        bit accepted;
        accepted = 1'b0;
        repeat (gap) @(posedge tb_clk);
        #2;
        pkt_data = p;
        pkt_vld  = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge tb_clk);
            if (pkt_rdy) begin
                accepted = 1'b1;
                break;
            end
        end
        @(posedge tb_clk);
        #2;
        pkt_vld = 1'b0;
        if (!accepted) failNow("accept_timeout");
    endtask

    task automatic waitIdle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge tb_clk);
            if (exp_sym.size() == 0 && !outstanding && !model_buf_full) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) failNow("wait_idle_timeout");
        repeat (10) @(posedge tb_clk);
    endtask

    initial begin
        int base;
        int base2;
        logic [71:0] p;
        bit hit;

        $display("[TB] start");
        repeat (4) @(posedge tb_clk);
        #2 tb_rst = 1'b0;
        @(posedge tb_clk);
        #1;
        checkOutput("rdy_after_reset", 72'(pkt_rdy), 72'd1);
        checkOutput("data_after_reset", 72'(sl_data), 72'd0);

        ack_req++;
        repeat (12) @(posedge tb_clk);
        #1;
        checkOutput("linkup_no_ack_err", 72'(ack_err_cnt), 72'd0);
        checkOutput("data_idle_zero", 72'(sl_data), 72'd0);

        base = pin_log.size();
        applyStimulus({32'h0, 32'h00000001, 8'h00}, 0);
        waitIdle(2000);
        checkOutput("short_sym_count", 72'(pin_log.size() - base), 72'd11);
        if (pin_log.size() >= base + 3) begin
            checkOutput("short_pin0", 72'(pin_log[base]),     72'(7'b0010001));
            checkOutput("short_pin1", 72'(pin_log[base + 1]), 72'(7'b0000000));
            checkOutput("short_pin2", 72'(pin_log[base + 2]), 72'(7'b0010010));
        end else begin
            failNow("short_pins_missing");
        end

        base = pin_log.size();
        applyStimulus({32'hA5A5A5AB, 32'h00000007, 8'h42}, 3);
        waitIdle(3000);
        checkOutput("long_sym_count", 72'(pin_log.size() - base), 72'd19);
        checkOutput("long_pkt_bits", last_rx_pkt, 72'hA5A5A5AB_00000007_42);

        base = rx_pkt_cnt;
        for (int i = 0; i < 26; i++) begin
            p = {$urandom, $urandom, 8'($urandom)};
            p[1:0] = 2'(i % 4);
            applyStimulus(p, 200 - 5 * i);
        end
        for (int i = 0; i < 4; i++) begin
            p = {$urandom, $urandom, 8'($urandom)};
            applyStimulus(p, 0);
        end
        waitIdle(20000);
        checkOutput("stream_pkt_count", 72'(rx_pkt_cnt - base), 72'd30);

        base  = tmo_err_cnt;
        base2 = rx_pkt_cnt;
        tmo_req++;
        applyStimulus({32'h12345678, 32'h9ABCDEF0, 8'h02}, 1);
        waitIdle(TMO_CYCLES + 3000);
        checkOutput("tmo_pulse_count", 72'(tmo_err_cnt - base), 72'd1);
        checkOutput("tmo_pkt_delivered", 72'(rx_pkt_cnt - base2), 72'd1);

        base = ack_err_cnt;
        ack_req++;
        repeat (20) @(posedge tb_clk);
        checkOutput("spurious_ack_err", 72'(ack_err_cnt - base), 72'd1);

        base = rx_sym_total;
        applyStimulus({32'hDEADBEEF, 32'hCAFEF00D, 8'hFE}, 2);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge tb_clk);
            if (rx_sym_total >= base + 6) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) failNow("mid_packet_wait_timeout");
        @(posedge tb_clk);
        #2 tb_rst = 1'b1;
        #1;
        checkOutput("mid_reset_data", 72'(sl_data), 72'd0);
        checkOutput("mid_reset_rdy", 72'(pkt_rdy), 72'd0);
        repeat (3) @(posedge tb_clk);
        #2 tb_rst = 1'b0;
        @(posedge tb_clk);
        #1;
        checkOutput("rdy_after_mid_reset", 72'(pkt_rdy), 72'd1);
        ack_req++;
        base = rx_pkt_cnt;
        applyStimulus({32'h0BADF00D, 32'h76543210, 8'h01}, 5);
        waitIdle(2000);
        checkOutput("post_reset_pkt", 72'(rx_pkt_cnt - base), 72'd1);

        checkOutput("ack_err_total", 72'(ack_err_cnt), 72'(exp_ack_err));
        checkOutput("tmo_err_total", 72'(tmo_err_cnt), 72'(exp_tmo_err));
        checkOutput("exp_queue_empty", 72'(exp_sym.size() + exp_pkt.size()), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
